// File: rtl/vga_timing_monitor.sv
// VGA sync timing monitor: measures line, hsync and frame timing,
// tracks lock against nominal 640x480@60 and counts timing errors.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pix_en,
    input  logic          vga_hsync,
    input  logic          vga_vsync,
    output logic          locked,
    output logic          frame_start,
    output logic          err_pulse,
    output logic [CW-1:0] h_total_meas,
    output logic [CW-1:0] h_sync_meas,
    output logic [CW-1:0] v_total_meas,
    output logic [15:0]   frame_count,
    output logic [7:0]    error_count
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] CMAX    = '1;
    localparam logic [CW-1:0] H_TOT_C = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_SYN_C = CW'(H_SYNC);
    localparam logic [CW-1:0] V_TOT_C = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_LIM_C = CW'(2 * V_TOTAL);
    localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic          hs_q, vs_q;
    logic [CW-1:0] h_cnt_q, hw_cnt_q, v_cnt_q;
    logic [CW-1:0] h_total_q, h_sync_q, v_total_q;
    logic [15:0]   fcnt_q;
    logic [7:0]    ecnt_q;
    logic          first_q, lbad_q, locked_q;

    logic          hs_act, hs_q_act, vs_act, vs_q_act;
    logic          hs_fall, hs_rise, vs_fall;
    logic          h_full, timeout, line_bad, frame_bad, err_d;
    logic [CW-1:0] v_meas;

    assign hs_act   = (vga_hsync == SYNC_POL);
    assign vs_act   = (vga_vsync == SYNC_POL);
    assign hs_q_act = (hs_q == SYNC_POL);
    assign vs_q_act = (vs_q == SYNC_POL);

    assign hs_fall = pix_en & ~hs_q_act & hs_act;
    assign hs_rise = pix_en & hs_q_act & ~hs_act;
    assign vs_fall = pix_en & ~vs_q_act & vs_act;

    assign h_full  = (h_cnt_q == CMAX);
    assign timeout = pix_en & (h_full | (v_cnt_q > V_LIM_C));

    // h_sync_q holds the width captured at this line's hsync release
    assign line_bad = hs_fall & ~first_q & (state_q != SEARCH)
                    & ((h_cnt_q != H_TOT_C) | (h_sync_q != H_SYN_C));

    // a line ending on the vsync edge belongs to the closing frame
    assign v_meas    = v_cnt_q + {{(CW-1){1'b0}}, hs_fall};
    assign frame_bad = (v_meas != V_TOT_C) | lbad_q | line_bad;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (pix_en) begin
            unique case (state_q)
                SEARCH: begin
                    if (!timeout && vs_fall) begin
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                MEASURE: begin
                    if (timeout) begin
                        state_d = SEARCH;
                    end else if (vs_fall) begin
                        if (frame_bad) begin
                            good_d = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                            if (good_d == LOCK_C) state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (timeout | line_bad | (vs_fall & frame_bad)) begin
                        state_d = SEARCH;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= SEARCH;
            good_q    <= '0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            h_cnt_q   <= '0;
            hw_cnt_q  <= '0;
            v_cnt_q   <= '0;
            h_total_q <= '0;
            h_sync_q  <= '0;
            v_total_q <= '0;
            fcnt_q    <= '0;
            ecnt_q    <= '0;
            first_q   <= 1'b1;
            lbad_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            locked_q <= (state_d == LOCKED);
            if (pix_en) begin
                state_q <= state_d;
                good_q  <= good_d;
                hs_q    <= vga_hsync;
                vs_q    <= vga_vsync;

                if (hs_fall) begin
                    h_total_q <= h_cnt_q;
                    h_cnt_q   <= {{(CW-1){1'b0}}, 1'b1};
                end else if (!h_full) begin
                    h_cnt_q <= h_cnt_q + 1'b1;
                end

                if (hs_rise) begin
                    h_sync_q <= hw_cnt_q;
                    hw_cnt_q <= '0;
                end else if (hs_act && hw_cnt_q != CMAX) begin
                    hw_cnt_q <= hw_cnt_q + 1'b1;
                end

                if (vs_fall) begin
                    v_total_q <= v_meas;
                    v_cnt_q   <= '0;
                    fcnt_q    <= fcnt_q + 1'b1;
                end else if (hs_fall && v_cnt_q != CMAX) begin
                    v_cnt_q <= v_cnt_q + 1'b1;
                end

                if (err_d && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 1'b1;

                // the first line after SEARCH may be partial or stale
                if (state_d == SEARCH) begin
                    first_q <= 1'b1;
                end else if (hs_fall && state_q != SEARCH) begin
                    first_q <= 1'b0;
                end

                if (state_d == SEARCH || vs_fall) begin
                    lbad_q <= 1'b0;
                end else if (line_bad) begin
                    lbad_q <= 1'b1;
                end
            end
        end
    end

    assign locked       = locked_q;
    assign frame_start  = vs_fall & reset_n;
    assign err_pulse    = err_d & reset_n;
    assign h_total_meas = h_total_q;
    assign h_sync_meas  = h_sync_q;
    assign v_total_meas = v_total_q;
    assign frame_count  = fcnt_q;
    assign error_count  = ecnt_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor with a scaled-down timing
// (32 ticks/line, hsync 5, 9 lines/frame, CW=6).
module tb_vga_timing_monitor;

    localparam int H  = 32;
    localparam int HS = 5;
    localparam int V  = 9;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_en = 1'b0;
    logic          vga_hsync = 1'b1;
    logic          vga_vsync = 1'b1;
    logic          locked, frame_start, err_pulse;
    logic [CW-1:0] h_total_meas, h_sync_meas, v_total_meas;
    logic [15:0]   frame_count;
    logic [7:0]    error_count;

    int tests = 0;
    int fails = 0;
    int tick_no = 0;
    int err_seen = 0;
    int fs_seen = 0;
    int err_tick = -1;
    int gate_bad = 0;
    logic lk_a, lk_b, err_lk_a, err_lk_b;

    vga_timing_monitor #(
        .H_TOTAL(H), .H_SYNC(HS), .V_TOTAL(V),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2), .CW(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .locked(locked), .frame_start(frame_start),
        .err_pulse(err_pulse),
        .h_total_meas(h_total_meas),
        .h_sync_meas(h_sync_meas),
        .v_total_meas(v_total_meas),
        .frame_count(frame_count),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   hw;
        int   vs_off;
        int   nlines;
        int   bad_line;
        int   bad_len;
        int   nframes;
        logic exp_lk;
        int   exp_err;
        int   exp_hs;
        int   exp_ht;
        int   exp_vt;
    } vec_t;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one pixel tick = one clk with pix_en high, one clk low
    task automatic tick(input logic hs, input logic vs);
        @(negedge clk);
        vga_hsync = hs;
        vga_vsync = vs;
        pix_en = 1'b1;
        #2;
        lk_a = locked;
        if (frame_start === 1'b1) fs_seen++;
        if (err_pulse === 1'b1) begin
            err_seen++;
            err_tick = tick_no;
            err_lk_a = locked;
        end
        @(negedge clk);
        pix_en = 1'b0;
        #2;
        lk_b = locked;
        if (err_tick == tick_no) err_lk_b = locked;
        if (err_pulse !== 1'b0 || frame_start !== 1'b0) gate_bad++;
        tick_no++;
    endtask

    task automatic frame(input int hw, input int vs_off,
                         input int nlines, input int bad_line,
                         input int bad_len, input int skip);
        int len;
        int p;
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : H;
            for (int t = 0; t < len; t++) begin
                p = l * H + t;
                if (!(l == 0 && t < skip)) begin
                    tick((t < hw) ? 1'b0 : 1'b1,
                         (p >= vs_off && p < vs_off + 2 * H) ? 1'b0 : 1'b1);
                end
            end
        end
    endtask

    task automatic relock(input string name);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < 6) begin
            frame(HS, 0, V, -1, 0, 0);
            n++;
        end
        chk(name, locked, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int base;
        int chg;
        int exp_fc;

        vecs[0] = '{HS-1, 0, V, -1, 0, 4, 1'b0, 0, HS-1, H, V};
        vecs[1] = '{HS,   0, V, -1, 0, 3, 1'b1, 0, HS,   H, V};
        vecs[2] = '{HS,   7, V, -1, 0, 3, 1'b1, 0, HS,   H, V};
        vecs[3] = '{HS,   0, V, 4, H+1, 1, 1'b0, 1, HS,  H, V};
        vecs[4] = '{HS,   0, V, -1, 0, 3, 1'b1, 1, HS,   H, V};
        vecs[5] = '{HS,   0, V, 4, H-1, 1, 1'b0, 2, HS,  H, V};
        vecs[6] = '{HS,   0, V+1, -1, 0, 3, 1'b0, 2, HS, H, V+1};
        vecs[7] = '{HS,   0, V, -1, 0, 3, 1'b1, 2, HS,   H, V};

        repeat (3) @(negedge clk);
        #2;
        chk("reset_locked", locked, 0);
        chk("reset_counts", {frame_count, error_count}, 0);
        chk("reset_meas",
            {h_total_meas, h_sync_meas, v_total_meas}, 0);
        reset_n = 1'b1;

        // lock after two checked frames, one clk after 3rd vsync
        frame(HS, 0, V, -1, 0, 0);
        frame(HS, 0, V, -1, 0, 0);
        chk("no_lock_yet", locked, 0);
        tick(1'b0, 1'b0);
        chk("lock_at_vsync", lk_a, 0);
        chk("lock_next_clk", lk_b, 1);
        frame(HS, 0, V, -1, 0, 1);
        chk("t1_v_total", v_total_meas, V);
        chk("t1_h_total", h_total_meas, H);
        chk("t1_h_sync", h_sync_meas, HS);
        chk("t1_frames", frame_count, 3);
        chk("t1_fs_pulses", fs_seen, 3);
        chk("t1_errors", error_count, 0);

        // one long line while locked
        err_seen = 0;
        base = tick_no;
        frame(HS, 0, V, 4, H + 1, 0);
        chk("t2_err_pulses", err_seen, 1);
        chk("t2_err_tick", err_tick, base + 4 * H + H + 1);
        chk("t2_locked_at_err", err_lk_a, 1);
        chk("t2_unlock_next", err_lk_b, 0);
        chk("t2_err_count", error_count, 1);
        frame(HS, 0, V, -1, 0, 0);
        frame(HS, 0, V, -1, 0, 0);
        chk("t2_not_relocked", locked, 0);
        frame(HS, 0, V, -1, 0, 0);
        chk("t2_relocked", locked, 1);

        // hsync stuck: h_cnt saturates at 63 on hold tick 31
        err_seen = 0;
        base = tick_no;
        repeat (70) tick(1'b1, 1'b1);
        chk("t5_err_pulses", err_seen, 1);
        chk("t5_err_tick", err_tick, base + 31);
        chk("t5_locked_at_err", err_lk_a, 1);
        chk("t5_err_count", error_count, 2);
        chk("t5_unlocked", locked, 0);
        relock("t5_relock");

        frame(HS, 0, V, 4, H - 1, 0);
        chk("t6_err_count3", error_count, 3);
        relock("t6_relock");
        frame(HS, 0, 3, -1, 0, 0);
        chk("t6_locked_pre", locked, 1);

        @(negedge clk);
        reset_n = 1'b0;
        pix_en = 1'b0;
        @(negedge clk);
        #2;
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_counts", {frame_count, error_count}, 0);
        chk("t6_rst_meas",
            {h_total_meas, h_sync_meas, v_total_meas}, 0);
        chk("t6_rst_pulses", {err_pulse, frame_start}, 0);
        reset_n = 1'b1;
        chg = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vga_hsync = 1'($urandom);
            vga_vsync = 1'($urandom);
            #2;
            if ({locked, frame_start, err_pulse, h_total_meas,
                 h_sync_meas, v_total_meas, frame_count,
                 error_count} !== '0) chg++;
        end
        chk("t6_idle_changes", chg, 0);

        exp_fc = 0;
        for (int i = 0; i < 8; i++) begin
            for (int f = 0; f < vecs[i].nframes; f++) begin
                frame(vecs[i].hw, vecs[i].vs_off, vecs[i].nlines,
                      vecs[i].bad_line, vecs[i].bad_len, 0);
            end
            exp_fc += vecs[i].nframes;
            chk($sformatf("v%0d_locked", i), locked, vecs[i].exp_lk);
            chk($sformatf("v%0d_errs", i), error_count, vecs[i].exp_err);
            chk($sformatf("v%0d_hsync", i), h_sync_meas, vecs[i].exp_hs);
            chk($sformatf("v%0d_htot", i), h_total_meas, vecs[i].exp_ht);
            chk($sformatf("v%0d_vtot", i), v_total_meas, vecs[i].exp_vt);
            chk($sformatf("v%0d_frames", i), frame_count, exp_fc);
        end

        chk("pulse_gating", gate_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
